// File: rtl/cmd_frame_master.sv
// rtl/cmd_frame_master.sv - host-side initiator for the byte-framed register/ALU command protocol
//
// Takes one command at a time, sends its frame byte by byte to a UART transmitter,
// collects the response bytes from a UART receiver and issues one completion pulse.
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   cmd_valid/cmd_ready command handshake; cmd_ready is high only in IDLE
//   cmd_op              0=reg write, 1=reg read, 2=ALU with operands, 3=ALU no operands
//   cmd_addr, cmd_data  register address / write data
//   cmd_opa, cmd_opb    ALU operands
//   cmd_fun             ALU function code
//   tx_data/tx_valid    frame byte towards the UART transmitter, held until tx_ready
//   tx_ready            transmitter accepts the presented byte
//   rx_data/rx_valid    response byte strobe from the UART receiver
//   rsp_valid           one-cycle completion pulse
//   rsp_data, rsp_err   response value and timeout flag, held until the next completion
module cmd_frame_master #(
   parameter int W       = 8,
   parameter int S       = 4,
   parameter int A       = 4,
   parameter int TO_W    = 16,
   parameter int TIMEOUT = 50000
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           cmd_valid,
   output logic           cmd_ready,
   input  logic [1:0]     cmd_op,
   input  logic [A-1:0]   cmd_addr,
   input  logic [W-1:0]   cmd_data,
   input  logic [W-1:0]   cmd_opa,
   input  logic [W-1:0]   cmd_opb,
   input  logic [S-1:0]   cmd_fun,
   output logic [W-1:0]   tx_data,
   output logic           tx_valid,
   input  logic           tx_ready,
   input  logic [W-1:0]   rx_data,
   input  logic           rx_valid,
   output logic           rsp_valid,
   output logic [2*W-1:0] rsp_data,
   output logic           rsp_err
);

   typedef enum logic [1:0] {IDLE, SEND, WAIT_RSP, DONE} state_t;

   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

   state_t         state;
   logic [1:0]     op_q;
   logic [A-1:0]   addr_q;
   logic [W-1:0]   data_q;
   logic [W-1:0]   opa_q;
   logic [W-1:0]   opb_q;
   logic [S-1:0]   fun_q;
   logic [1:0]     idx;
   logic           rx_cnt;
   logic [W-1:0]   rx_lo;
   logic [TO_W-1:0] to_cnt;
   logic [W-1:0]   nxt_byte;

   function automatic logic [W-1:0] frame_byte(
      input logic [1:0]   op,
      input logic [1:0]   i,
      input logic [A-1:0] addr,
      input logic [W-1:0] data,
      input logic [W-1:0] opa,
      input logic [W-1:0] opb,
      input logic [S-1:0] fun
   );
      logic [W-1:0] b;
      b = '0;
      case (op)
         2'd0: begin
            case (i)
               2'd0:    b = W'(8'hAA);
               2'd1:    b = W'(addr);
               default: b = data;
            endcase
         end
         2'd1: b = (i == 2'd0) ? W'(8'hBB) : W'(addr);
         2'd2: begin
            case (i)
               2'd0:    b = W'(8'hCC);
               2'd1:    b = opa;
               2'd2:    b = opb;
               default: b = W'(fun);
            endcase
         end
         default: b = (i == 2'd0) ? W'(8'hDD) : W'(fun);
      endcase
      return b;
   endfunction

   function automatic logic [1:0] last_idx(input logic [1:0] op);
      case (op)
         2'd0:    return 2'd2;
         2'd2:    return 2'd3;
         default: return 2'd1;
      endcase
   endfunction

   // Byte following the one currently presented, from the latched fields.
   always_comb begin
      nxt_byte = frame_byte(op_q, idx + 2'd1, addr_q, data_q, opa_q, opb_q, fun_q);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         cmd_ready <= 1'b1;
         tx_valid  <= 1'b0;
         tx_data   <= '0;
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
         rsp_err   <= 1'b0;
         op_q      <= '0;
         addr_q    <= '0;
         data_q    <= '0;
         opa_q     <= '0;
         opb_q     <= '0;
         fun_q     <= '0;
         idx       <= '0;
         rx_cnt    <= 1'b0;
         rx_lo     <= '0;
         to_cnt    <= '0;
      end else begin
         rsp_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (cmd_valid && cmd_ready) begin
                  op_q      <= cmd_op;
                  addr_q    <= cmd_addr;
                  data_q    <= cmd_data;
                  opa_q     <= cmd_opa;
                  opb_q     <= cmd_opb;
                  fun_q     <= cmd_fun;
                  idx       <= 2'd0;
                  tx_data   <= frame_byte(cmd_op, 2'd0, cmd_addr, cmd_data, cmd_opa, cmd_opb, cmd_fun);
                  tx_valid  <= 1'b1;
                  cmd_ready <= 1'b0;
                  state     <= SEND;
               end
            end
            SEND: begin
               // tx_valid is always high here, so tx_ready alone completes a transfer.
               if (tx_ready) begin
                  if (idx == last_idx(op_q)) begin
                     tx_valid <= 1'b0;
                     if (op_q == 2'd0) begin
                        rsp_data  <= '0;
                        rsp_err   <= 1'b0;
                        rsp_valid <= 1'b1;
                        state     <= DONE;
                     end else begin
                        rx_cnt <= 1'b0;
                        to_cnt <= '0;
                        state  <= WAIT_RSP;
                     end
                  end else begin
                     idx     <= idx + 2'd1;
                     tx_data <= nxt_byte;
                  end
               end
            end
            WAIT_RSP: begin
               // A byte arriving on the expiry cycle takes priority over the timeout.
               if (rx_valid) begin
                  to_cnt <= '0;
                  if (op_q == 2'd1) begin
                     rsp_data  <= {{W{1'b0}}, rx_data};
                     rsp_err   <= 1'b0;
                     rsp_valid <= 1'b1;
                     state     <= DONE;
                  end else if (rx_cnt) begin
                     rsp_data  <= {rx_data, rx_lo};
                     rsp_err   <= 1'b0;
                     rsp_valid <= 1'b1;
                     state     <= DONE;
                  end else begin
                     rx_lo  <= rx_data;
                     rx_cnt <= 1'b1;
                  end
               end else if (to_cnt == TO_LAST) begin
                  rsp_data  <= '0;
                  rsp_err   <= 1'b1;
                  rsp_valid <= 1'b1;
                  state     <= DONE;
               end else begin
                  to_cnt <= to_cnt + 1'b1;
               end
            end
            default: begin
               cmd_ready <= 1'b1;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cmd_frame_master.sv
// tb/tb_cmd_frame_master.sv - self-checking bench for cmd_frame_master
module tb_cmd_frame_master;

   localparam int TO = 20;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [1:0]  cmd_op;
   logic [3:0]  cmd_addr;
   logic [7:0]  cmd_data;
   logic [7:0]  cmd_opa;
   logic [7:0]  cmd_opb;
   logic [3:0]  cmd_fun;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rsp_valid;
   logic [15:0] rsp_data;
   logic        rsp_err;

   always #5 clk = ~clk;

   cmd_frame_master #(.W(8), .S(4), .A(4), .TO_W(16), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_opa(cmd_opa),
      .cmd_opb(cmd_opb), .cmd_fun(cmd_fun),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .rx_data(rx_data), .rx_valid(rx_valid),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err)
   );

   int n_cmp  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // rdy: 0 = tx_ready always high, 1 = toggles 1-0-1, 2 = random
   typedef struct {
      logic [1:0]  op;
      logic [3:0]  addr;
      logic [7:0]  data, opa, opb;
      logic [3:0]  fun;
      int          rdy;
      int          g0, g1;
      logic [7:0]  r0, r1;
      int          len;
      logic [31:0] fb;
      logic [15:0] rsp;
      logic        err;
      int          lat;
   } vec_t;

   function automatic vec_t mk(input logic [1:0] op, input logic [3:0] addr, input logic [7:0] data,
                               input logic [7:0] opa, input logic [7:0] opb, input logic [3:0] fun,
                               input int rdy, input int g0, input logic [7:0] r0, input int g1,
                               input logic [7:0] r1, input int len, input logic [31:0] fb,
                               input logic [15:0] rsp, input logic err, input int lat);
      vec_t v;
      v.op = op; v.addr = addr; v.data = data; v.opa = opa; v.opb = opb; v.fun = fun;
      v.rdy = rdy; v.g0 = g0; v.r0 = r0; v.g1 = g1; v.r1 = r1;
      v.len = len; v.fb = fb; v.rsp = rsp; v.err = err; v.lat = lat;
      return v;
   endfunction

   // Reference: frame layout from the protocol table; response window arithmetic where
   // each expected byte must arrive within TO cycles of the previous event.
   function automatic vec_t model(input vec_t v_in);
      vec_t v;
      int t;
      int nexp;
      int g;
      logic [7:0] b0, b1;
      v = v_in;
      case (v.op)
         2'd0: begin v.len = 3; v.fb = {8'h00, v.data, 4'h0, v.addr, 8'hAA}; end
         2'd1: begin v.len = 2; v.fb = {16'h0000, 4'h0, v.addr, 8'hBB}; end
         2'd2: begin v.len = 4; v.fb = {4'h0, v.fun, v.opb, v.opa, 8'hCC}; end
         default: begin v.len = 2; v.fb = {16'h0000, 4'h0, v.fun, 8'hDD}; end
      endcase
      nexp = (v.op == 2'd0) ? 0 : (v.op == 2'd1) ? 1 : 2;
      t = 0; v.err = 1'b0; b0 = 8'h00; b1 = 8'h00;
      for (int k = 0; k < nexp; k++) begin
         g = (k == 0) ? v.g0 : v.g1;
         if (g <= TO - 1) begin
            if (k == 0) b0 = v.r0; else b1 = v.r1;
            t += g + 1;
         end else begin
            v.err = 1'b1;
            t += TO;
            break;
         end
      end
      v.lat = t;
      if (v.err || v.op == 2'd0) v.rsp = 16'h0000;
      else if (v.op == 2'd1)     v.rsp = {8'h00, b0};
      else                       v.rsp = {b1, b0};
      return v;
   endfunction

   task automatic run_cmd(input vec_t v);
      int cyc, sent, w, k, since, nexp, lat;
      bit in_wait, enter, done;
      logic [15:0] got_d;
      logic        got_e;
      logic [7:0]  eb;
      nexp = (v.op == 2'd0) ? 0 : (v.op == 2'd1) ? 1 : 2;
      @(posedge clk); #1;
      cmd_valid = 1'b1; cmd_op = v.op; cmd_addr = v.addr; cmd_data = v.data;
      cmd_opa = v.opa; cmd_opb = v.opb; cmd_fun = v.fun;
      @(negedge clk);
      chk("idle_ready", cmd_ready, 1);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      cmd_op = 2'($urandom); cmd_addr = 4'($urandom); cmd_data = 8'($urandom);
      cmd_opa = 8'($urandom); cmd_opb = 8'($urandom); cmd_fun = 4'($urandom);
      cyc = 0; sent = 0; w = 0; k = 0; since = 0; lat = -1;
      in_wait = 0; done = 0; got_d = '0; got_e = 1'b0;
      while (!done && cyc < 400) begin
         case (v.rdy)
            0:       tx_ready = 1'b1;
            1:       tx_ready = (cyc % 2 == 0);
            default: tx_ready = 1'($urandom);
         endcase
         rx_valid = 1'b0;
         if (in_wait && k < nexp) begin
            if (since == ((k == 0) ? v.g0 : v.g1)) begin
               rx_valid = 1'b1;
               rx_data  = (k == 0) ? v.r0 : v.r1;
               k++;
               since = 0;
            end else begin
               since++;
            end
         end
         enter = 0;
         @(negedge clk);
         if (tx_valid) begin
            if (sent < v.len) begin
               eb = v.fb[8*sent +: 8];
               chk($sformatf("tx_byte%0d", sent), tx_data, eb);
               if (tx_ready) begin
                  sent++;
                  if (sent == v.len) enter = 1;
               end
            end else begin
               chk("tx_extra", sent + 1, v.len);
            end
         end
         if (rsp_valid) begin
            lat = in_wait ? w : -2;
            got_d = rsp_data;
            got_e = rsp_err;
            chk("busy_ready", cmd_ready, 0);
            done = 1;
         end
         if (in_wait) w++;
         if (enter) in_wait = 1;
         @(posedge clk); #1;
         cyc++;
      end
      tx_ready = 1'b0;
      rx_valid = 1'b0;
      if (!done) chk("rsp_timeout", 0, 1);
      chk("tx_len", sent, v.len);
      chk("rsp_data", got_d, v.rsp);
      chk("rsp_err", got_e, v.err);
      chk("rsp_lat", lat, v.lat);
      @(negedge clk);
      chk("ready_after", cmd_ready, 1);
      chk("rsp_pulse", rsp_valid, 0);
      chk("rsp_hold", rsp_data, v.rsp);
   endtask

   vec_t tbl[8];
   vec_t rv;
   int   bad;

   initial begin
      rst = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_addr = '0; cmd_data = '0;
      cmd_opa = '0; cmd_opb = '0; cmd_fun = '0; tx_ready = 1'b0; rx_data = '0; rx_valid = 1'b0;

      //            op    addr  data   opa    opb    fun  rdy g0  r0     g1  r1     len fb            rsp       err lat
      tbl[0] = mk(2'd0, 4'h5, 8'h3C, 8'h00, 8'h00, 4'h0, 0, 0,  8'h00, 0,  8'h00, 3, 32'h003C05AA, 16'h0000, 0, 0);
      tbl[1] = mk(2'd1, 4'h2, 8'h00, 8'h00, 8'h00, 4'h0, 0, 5,  8'h7E, 0,  8'h00, 2, 32'h000002BB, 16'h007E, 0, 6);
      tbl[2] = mk(2'd2, 4'h0, 8'h00, 8'h12, 8'h34, 4'h1, 1, 3,  8'h46, 2,  8'h00, 4, 32'h013412CC, 16'h0046, 0, 7);
      tbl[3] = mk(2'd3, 4'h0, 8'h00, 8'h00, 8'h00, 4'h2, 0, 99, 8'h00, 0,  8'h00, 2, 32'h000002DD, 16'h0000, 1, 20);
      tbl[4] = mk(2'd3, 4'h0, 8'h00, 8'h00, 8'h00, 4'h7, 0, 4,  8'hAB, 99, 8'h00, 2, 32'h000007DD, 16'h0000, 1, 25);
      tbl[5] = mk(2'd3, 4'h0, 8'h00, 8'h00, 8'h00, 4'h0, 0, 19, 8'h11, 19, 8'h22, 2, 32'h000000DD, 16'h2211, 0, 40);
      tbl[6] = mk(2'd2, 4'h0, 8'h00, 8'hFF, 8'h80, 4'hF, 2, 20, 8'h99, 0,  8'h00, 4, 32'h0F80FFCC, 16'h0000, 1, 20);
      tbl[7] = mk(2'd1, 4'hF, 8'h00, 8'h00, 8'h00, 4'h0, 0, 0,  8'hC3, 0,  8'h00, 2, 32'h00000FBB, 16'h00C3, 0, 1);

      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_cmd_ready", cmd_ready, 1);
      chk("rst_tx_valid", tx_valid, 0);
      chk("rst_tx_data", tx_data, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_data", rsp_data, 0);
      chk("rst_rsp_err", rsp_err, 0);
      @(posedge clk); #1;
      rst = 1'b1;

      for (int i = 0; i < 8; i++) run_cmd(tbl[i]);

      for (int i = 0; i < 40; i++) begin
         rv = mk(2'($urandom), 4'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 4'($urandom),
                 2, ($urandom_range(0, 7) == 0) ? $urandom_range(TO, TO + 4) : $urandom_range(0, TO - 1),
                 8'($urandom),
                 ($urandom_range(0, 7) == 0) ? $urandom_range(TO, TO + 4) : $urandom_range(0, TO - 1),
                 8'($urandom), 0, 32'h0, 16'h0, 1'b0, 0);
         run_cmd(model(rv));
      end

      // Reset while the third byte of an op2 frame is being presented.
      @(posedge clk); #1;
      cmd_valid = 1'b1; cmd_op = 2'd2; cmd_opa = 8'h5A; cmd_opb = 8'hA5; cmd_fun = 4'h3;
      @(posedge clk); #1;
      cmd_valid = 1'b0; tx_ready = 1'b1;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      chk("mid_tx_valid", tx_valid, 1);
      chk("mid_tx_data", tx_data, 8'hA5);
      #2 rst = 1'b0;
      #1;
      chk("arst_tx_valid", tx_valid, 0);
      chk("arst_cmd_ready", cmd_ready, 1);
      chk("arst_rsp_valid", rsp_valid, 0);
      tx_ready = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      bad = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (rsp_valid || tx_valid || !cmd_ready) bad++;
      end
      chk("post_rst_quiet", bad, 0);
      @(posedge clk); #1;
      rx_valid = 1'b1; rx_data = 8'h55;
      @(posedge clk); #1;
      rx_valid = 1'b0;
      run_cmd(mk(2'd1, 4'h9, 8'h00, 8'h00, 8'h00, 4'h0, 0, 2, 8'h7E, 0, 8'h00,
                 2, 32'h000009BB, 16'h007E, 0, 3));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/cmd_frame_master.md
Name: cmd_frame_master

Overview:
- Host-side initiator for the byte-framed register/ALU command protocol served by the system controller.
- Accepts one command per request, serializes it into the framed byte sequence for a UART transmitter, then collects the response bytes from a UART receiver.
- Issues one completion pulse per command, carrying the assembled response or a timeout error.
- Used in the loopback test harness and on the host-bridge side of the link.

Parameters:
W, 8, byte/data width
S, 4, ALU function code width
A, 4, register address width
TO_W, 16, timeout counter width
TIMEOUT, 50000, clk cycles allowed per response byte (must be < 2^TO_W)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-low
cmd_valid  in  1  command request
cmd_ready  out  1  master can accept a command
cmd_op  in  2  0=reg write, 1=reg read, 2=ALU with operands, 3=ALU no operands
cmd_addr  in  A  register address (ops 0,1)
cmd_data  in  W  write data (op 0)
cmd_opa  in  W  operand A (op 2)
cmd_opb  in  W  operand B (op 2)
cmd_fun  in  S  ALU function (ops 2,3)
tx_data  out  W  byte to UART TX
tx_valid  out  1  tx_data valid
tx_ready  in  1  UART TX accepts byte
rx_data  in  W  byte from UART RX
rx_valid  in  1  one-cycle strobe, rx_data valid
rsp_valid  out  1  one-cycle completion pulse
rsp_data  out  2W  response value
rsp_err  out  1  timeout flag, qualified by rsp_valid

Behaviour:
- Reset (rst low, any state): state=IDLE; cmd_ready=1; tx_valid=0; tx_data=0; rsp_valid=0; rsp_data=0; rsp_err=0; byte index=0; timeout counter=0; latched fields=0. Any in-flight command is abandoned, with no completion pulse.
- Frames (byte 0 first):
  - op0: AA, addr, data
  - op1: BB, addr
  - op2: CC, opa, opb, fun
  - op3: DD, fun
  - addr and fun are zero-extended to W.
- States: IDLE, SEND, WAIT_RSP, DONE.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid & cmd_ready, latch op/addr/data/opa/opb/fun, set index=0, go to SEND. The first byte is presented on the next cycle.
  - cmd_ready=0 in every other state.
- SEND:
  - tx_valid=1 and tx_data=frame[index], both registered and held stable until tx_ready.
  - On tx_valid & tx_ready: if index is the last byte of the frame, leave SEND; otherwise index+1.
  - tx_ready high while tx_valid low has no effect.
  - After the last byte: op0 goes to DONE (rsp_data=0, rsp_err=0). Ops 1/2/3 go to WAIT_RSP with rx byte count=0 and timeout counter=0.
- WAIT_RSP:
  - Expected response bytes: op1 expects 1 byte; ops 2/3 expect 2 bytes (low, then high).
  - Each rx_valid stores rx_data into the next byte slot and clears the timeout counter. When the expected count is reached, go to DONE.
  - For op1, rsp_data = {0, byte}. For ops 2/3, rsp_data = {high, low}.
  - Timeout counter increments on each cycle without rx_valid. When it reaches TIMEOUT-1 without rx_valid, go to DONE with rsp_err=1 and rsp_data=0, discarding partial bytes.
  - rx_valid in the same cycle as expiry: the byte wins and the counter clears.
- DONE: rsp_valid=1 for exactly one cycle, then IDLE. rsp_data/rsp_err hold their value until the next completion.
- rx_valid outside WAIT_RSP is ignored and dropped; it is never buffered for the next command.
- Latency, op0 with tx_ready tied high: accept at cycle 0; bytes transfer at cycles 1, 2, 3; rsp_valid at cycle 4; cmd_ready high again at cycle 5.
- Back-to-back commands: a new command is accepted only in IDLE, one cycle after the rsp_valid pulse.
- Command fields changing after acceptance have no effect on the current frame.

Test Plan:
- Reset, then op0 addr=5 data=3C, tx_ready=1 -> tx bytes AA,05,3C on consecutive cycles; rsp_valid pulse one cycle later with rsp_err=0, rsp_data=0000.
- op1 addr=2, tx_ready=1, then rx_valid with rx_data=7E five cycles later -> tx bytes BB,02; rsp_valid with rsp_data=007E, rsp_err=0.
- op2 opa=12 opb=34 fun=1, tx_ready toggling 1-0-1 -> bytes CC,12,34,01 each held stable through stalls; rx 46 then 00 -> rsp_data=0046.
- op3 fun=2, with TIMEOUT overridden to 20 in the bench and no rx -> tx bytes DD,02; rsp_valid after 20 wait cycles with rsp_err=1, rsp_data=0000.
- op3, one rx byte arriving, then silence (TIMEOUT=20) -> timeout error and partial byte discarded. Separately, rx_valid on exactly the expiry cycle -> no error, counter restarts.
- rst asserted while in SEND after byte 2 of an op2 frame -> tx_valid=0 and cmd_ready=1 immediately, no rsp_valid; stray rx_valid in IDLE does not affect the next op1 response.
